core4_key_pio_in: RTL

//  Avalon-MM slave input PIO; counterpart of the LED output PIOs. Samples an

---
 rtl/core4_key_pio_in.sv | 118 +++++++++++
 1 files changed

// File: rtl/core4_key_pio_in.sv
// Avalon-MM input PIO: synchronises external key/switch inputs, latches
// selected edges in a write-1-to-clear capture register and raises a maskable level IRQ.
module core4_key_pio_in #(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } pio_addr_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [ARM_W-1:0] arm_cnt;

  logic             armed;
  logic             wr;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irqmask_next;
  logic [WIDTH-1:0] edgecapture_next;
  logic [31:0]      rd_mux;

  assign din   = sync_q[SYNC_STAGES-1];
  assign armed = (arm_cnt == ARM_W'(ARM_MAX));
  assign wr    = chipselect & ~write_n;
  assign rise  = din & ~prev;
  assign fall  = ~din & prev;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    edge_det = '0;
    if (armed) begin
      case (EDGE_TYPE)
        0:       edge_det = rise;
        1:       edge_det = fall;
        default: edge_det = rise | fall;
      endcase
    end
  end

  always_comb begin
    irqmask_next = irqmask;
    clr          = '0;
    if (wr && pio_addr_e'(address) == ADDR_MASK) irqmask_next = writedata[WIDTH-1:0];
    if (wr && pio_addr_e'(address) == ADDR_EDGE) clr = writedata[WIDTH-1:0];
    // A fresh edge outranks a clear arriving in the same cycle.
    edgecapture_next = edge_det | (edgecapture & ~clr);
  end

  always_comb begin
    rd_mux = '0;
    if (chipselect) begin
      case (pio_addr_e'(address))
        ADDR_DATA: rd_mux[WIDTH-1:0] = din;
        ADDR_MASK: rd_mux[WIDTH-1:0] = irqmask;
        ADDR_EDGE: rd_mux[WIDTH-1:0] = edgecapture;
        default:   rd_mux = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  // NOTE: the synchroniser array is reset like any other flop: din must read 0
  // while the arm window runs, so a held-high input never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev        <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      arm_cnt     <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev        <= din;
      irqmask     <= irqmask_next;
      edgecapture <= edgecapture_next;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
      readdata    <= rd_mux;
      irq         <= |(edgecapture_next & irqmask_next);
    end
  end

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule
